// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller slice.
//   - NPC operation codes understood by the next-PC unit.
//   - fetch_word_t: one fetched instruction tagged with its PC.
//   - word_align / is_misaligned: helpers for redirect-target handling.
package pc_fetch_ctrl_pkg;

    localparam logic [1:0] NPC_PLUS4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH   = 2'b01;
    localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
    localparam logic [1:0] NPC_JUMP_REG = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port.
//   req   : fetch request (controller -> memory)
//   addr  : fetch address (controller -> memory)
//   ready : memory delivers rdata this cycle (memory -> controller)
//   rdata : fetched word (memory -> controller)
interface pc_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry {instr,pc} skid buffer used when ID stalls while a fetch lands.
//   clk, rst : clock, asynchronous active-high reset (empties the buffer)
//   load     : push din at the tail
//   shift    : pop the head
//   clear    : discard all entries (redirect)
//   din      : word to push
//   head     : oldest entry, valid whenever the buffer is non-empty
module fetch_skid_buf
    import pc_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic        clear,
    input  fetch_word_t din,
    output fetch_word_t head
);

    logic [1:0]  count;
    fetch_word_t entry0;
    fetch_word_t entry1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({load, shift})
                2'b10:   if (count != 2'd2) count <= count + 2'd1;
                2'b01:   if (count != 2'd0) count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Payload carries no reset; count alone says what is meaningful.
    always_ff @(posedge clk) begin
        case ({load, shift})
            2'b10: begin
                if (count == 2'd0) entry0 <= din;
                else               entry1 <= din;
            end
            2'b01: entry0 <= entry1;
            2'b11: begin
                if (count == 2'd1) begin
                    entry0 <= din;
                end else begin
                    entry0 <= entry1;
                    entry1 <= din;
                end
            end
            default: ;
        endcase
    end

    assign head = entry0;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, selects the NPC operation, runs
// the instruction-memory handshake, buffers fetched words for ID, applies
// ID redirects with a one-cycle flush, and flags fetch errors.
//   clk, rst        : clock, asynchronous active-high reset
//   id_stall        : ID cannot consume if_instr this cycle
//   id_redirect     : ID resolved a taken control transfer (pulse)
//   id_redirect_op  : NPC operation for the redirect
//   npc             : next PC from the NPC unit for npc_op
//   npc_op          : NPC operation select (combinational)
//   if_pc           : current fetch PC
//   imem            : instruction-memory port (master side)
//   if_valid        : if_instr holds an unconsumed instruction
//   if_instr        : instruction presented to ID
//   if_instr_pc     : PC of if_instr
//   if_flush        : high the cycle after a redirect
//   fetch_err       : sticky timeout / misaligned-target flag
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             id_redirect,
    input  logic [1:0]       id_redirect_op,
    input  logic [31:0]      npc,
    output logic [1:0]       npc_op,
    output logic [31:0]      if_pc,
    pc_fetch_ctrl_if.master  imem,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_instr_pc,
    output logic             if_flush,
    output logic             fetch_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      drain_addr;
    logic [CNT_W-1:0] wait_cnt;

    logic        consume;
    logic        accept;
    logic        to_slot;
    logic        to_skid;
    logic        skid_shift;
    fetch_word_t skid_head;

    assign npc_op  = id_redirect ? id_redirect_op : NPC_PLUS4;
    assign if_pc   = pc;
    assign consume = if_valid && !id_stall;

    assign imem.req  = (state == ST_FETCH) || (state == ST_DRAIN);
    // The abandoned request keeps its original address until memory answers,
    // even though pc already points at the redirect target.
    assign imem.addr = (state == ST_DRAIN) ? drain_addr : pc;

    // A redirect outranks a word landing in the same cycle.
    assign accept     = (state == ST_FETCH) && imem.ready && !id_redirect;
    assign to_slot    = accept && (!if_valid || !id_stall);
    assign to_skid    = accept && if_valid && id_stall;
    assign skid_shift = (state == ST_HOLD) && !id_stall && !id_redirect;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (to_skid),
        .shift (skid_shift),
        .clear (id_redirect),
        .din   ('{instr: imem.rdata, pc: pc}),
        .head  (skid_head)
    );

    always_ff @(posedge clk) begin
        if (id_redirect && (state == ST_FETCH) && !imem.ready) begin
            drain_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_instr_pc <= 32'd0;
            if_flush    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if_flush <= id_redirect;

            if (id_redirect) begin
                pc       <= word_align(npc);
                if_valid <= 1'b0;
                if (is_misaligned(npc)) fetch_err <= 1'b1;
                // A request still in flight must be answered before the new
                // target can be fetched; its data is thrown away in DRAIN.
                if ((state == ST_DRAIN) || ((state == ST_FETCH) && !imem.ready))
                    state <= ST_DRAIN;
                else
                    state <= ST_FETCH;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_FETCH;
                    ST_FETCH: begin
                        if (imem.ready) begin
                            pc <= npc;
                            if (if_valid && id_stall) state <= ST_HOLD;
                        end
                    end
                    ST_HOLD:  if (!id_stall) state <= ST_FETCH;
                    ST_DRAIN: if (imem.ready) state <= ST_FETCH;
                    default:  state <= ST_IDLE;
                endcase

                if (to_slot) begin
                    if_valid    <= 1'b1;
                    if_instr    <= imem.rdata;
                    if_instr_pc <= pc;
                end else if (skid_shift) begin
                    // Old slot is consumed and refilled in the same cycle.
                    if_instr    <= skid_head.instr;
                    if_instr_pc <= skid_head.pc;
                end else if (consume) begin
                    if_valid <= 1'b0;
                end
            end

            // Wait counter saturates; the request itself keeps waiting.
            if (imem.req && !imem.ready) begin
                if (wait_cnt != TO_LIM) wait_cnt <= wait_cnt + 1'b1;
                if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST)) fetch_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by a randomized run
// checked by a program-order scoreboard.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned TO     = 4;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        id_redirect;
    logic [1:0]  id_redirect_op;
    logic [31:0] npc;
    logic [1:0]  npc_op;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_instr_pc;
    logic        if_flush;
    logic        fetch_err;
    logic [31:0] redir_target;
    logic        mem_ready;

    pc_fetch_ctrl_if imem();

    pc_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_stall       (id_stall),
        .id_redirect    (id_redirect),
        .id_redirect_op (id_redirect_op),
        .npc            (npc),
        .npc_op         (npc_op),
        .if_pc          (if_pc),
        .imem           (imem),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_instr_pc    (if_instr_pc),
        .if_flush       (if_flush),
        .fetch_err      (fetch_err)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // NPC unit model: sequential +4 (wrapping), otherwise the redirect target.
    always_comb begin
        npc = (npc_op == NPC_PLUS4) ? if_pc + 32'd4 : redir_target;
    end

    assign imem.ready = mem_ready;
    assign imem.rdata = mem_ready ? mem_word(imem.addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int n_consumed = 0;
    logic sb_on = 1'b0;

    typedef struct {
        logic [31:0] target;
        logic        mis;
    } redir_t;
    redir_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        id_stall = 1'b0;
        id_redirect = 1'b0;
        id_redirect_op = NPC_PLUS4;
        redir_target = 32'd0;
        mem_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: instructions reaching ID must follow program order
    // from RESET_PC, restarting at each redirect target (word aligned).
    initial begin : monitor
        logic        prev_redir;
        logic [31:0] exp_pc;
        logic        err_model;
        int          idle;
        redir_t      e;
        prev_redir = 1'b0;
        exp_pc = RST_PC;
        err_model = 1'b0;
        idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!sb_on) begin
                prev_redir = 1'b0;
                exp_pc = RST_PC;
                err_model = 1'b0;
                idle = 0;
            end else begin
                chk("sb_flush", if_flush, prev_redir);
                if (if_flush) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL sb_queue: flush with no pending redirect, want one queued");
                    end else begin
                        e = sb_q.pop_front();
                        exp_pc = {e.target[31:2], 2'b00};
                        err_model = err_model | e.mis;
                        chk("sb_flush_valid", if_valid, 1'b0);
                        chk("sb_fetch_err", fetch_err, err_model);
                    end
                end
                if (if_valid && !id_stall && !id_redirect) begin
                    chk("sb_pc", if_instr_pc, exp_pc);
                    chk("sb_instr", if_instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_consumed++;
                    idle = 0;
                end else begin
                    idle++;
                    if (idle == 300) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL sb_progress: %0d idle cycles, want fewer than 300", idle);
                        idle = 0;
                    end
                end
                prev_redir = id_redirect;
            end
        end
    end

    initial begin : main
        int     wait_run;
        logic   mis;
        redir_t r;

        // 1. Zero-wait memory after reset.
        do_reset(1'b1);
        chk("rst_req", imem.req, 1'b0);
        chk("rst_pc", if_pc, RST_PC);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_instr_pc", if_instr_pc, 32'd0);
        chk("rst_flush", if_flush, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        @(negedge clk);
        chk("t1_req", imem.req, 1'b1);
        chk("t1_addr0", imem.addr, 32'h3000);
        chk("t1_valid0", if_valid, 1'b0);
        @(negedge clk);
        chk("t1_addr1", imem.addr, 32'h3004);
        chk("t1_valid1", if_valid, 1'b1);
        chk("t1_instr1", if_instr, mem_word(32'h3000));
        chk("t1_ipc1", if_instr_pc, 32'h3000);
        @(negedge clk);
        chk("t1_addr2", imem.addr, 32'h3008);
        chk("t1_ipc2", if_instr_pc, 32'h3004);

        // 2. Memory answers three cycles late.
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_addr_hold", imem.addr, 32'h3000);
            chk("t2_valid_wait", if_valid, 1'b0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("t2_valid", if_valid, 1'b1);
        chk("t2_ipc", if_instr_pc, 32'h3000);
        chk("t2_pc", if_pc, 32'h3004);
        chk("t2_err", fetch_err, 1'b0);

        // 3. Stall while two words arrive.
        do_reset(1'b1);
        id_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_instr0", if_instr, mem_word(32'h3000));
        @(negedge clk);
        chk("t3_hold_req", imem.req, 1'b0);
        chk("t3_hold_instr", if_instr, mem_word(32'h3000));
        chk("t3_hold_pc", if_pc, 32'h3008);
        @(negedge clk);
        chk("t3_still_instr", if_instr, mem_word(32'h3000));
        id_stall = 1'b0;
        @(negedge clk);
        chk("t3_skid_instr", if_instr, mem_word(32'h3004));
        chk("t3_skid_ipc", if_instr_pc, 32'h3004);
        chk("t3_skid_valid", if_valid, 1'b1);
        chk("t3_resume_addr", imem.addr, 32'h3008);
        @(negedge clk);
        chk("t3_next_ipc", if_instr_pc, 32'h3008);

        // 4. Redirect with a fetch outstanding.
        do_reset(1'b0);
        @(negedge clk);
        id_redirect = 1'b1;
        id_redirect_op = NPC_JUMP_IMM;
        redir_target = 32'h3400;
        #1;
        chk("t4_npc_op", npc_op, NPC_JUMP_IMM);
        @(negedge clk);
        id_redirect = 1'b0;
        chk("t4_flush", if_flush, 1'b1);
        chk("t4_pc", if_pc, 32'h3400);
        chk("t4_drain_req", imem.req, 1'b1);
        chk("t4_drain_addr", imem.addr, 32'h3000);
        mem_ready = 1'b1;
        #1;
        chk("t4_npc_op_idle", npc_op, NPC_PLUS4);
        @(negedge clk);
        chk("t4_flush_off", if_flush, 1'b0);
        chk("t4_discard", if_valid, 1'b0);
        chk("t4_new_addr", imem.addr, 32'h3400);
        @(negedge clk);
        chk("t4_ipc", if_instr_pc, 32'h3400);
        chk("t4_instr", if_instr, mem_word(32'h3400));

        // PC wrap at the top of the address space.
        do_reset(1'b1);
        @(negedge clk);
        id_redirect = 1'b1;
        id_redirect_op = NPC_JUMP_REG;
        redir_target = 32'hFFFF_FFFC;
        @(negedge clk);
        id_redirect = 1'b0;
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc1", if_pc, 32'h0000_0000);
        chk("wrap_ipc", if_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_err", fetch_err, 1'b0);

        // 5. Misaligned redirect target.
        do_reset(1'b1);
        @(negedge clk);
        id_redirect = 1'b1;
        id_redirect_op = NPC_BRANCH;
        redir_target = 32'h3402;
        @(negedge clk);
        id_redirect = 1'b0;
        chk("t5_pc", if_pc, 32'h3400);
        chk("t5_err", fetch_err, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", fetch_err, 1'b1);
        chk("t5_ipc", if_instr_pc, 32'h3408);

        // 6. Timeout, then reset while the fetch is waiting.
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        chk("t6_err_w3", fetch_err, 1'b0);
        @(negedge clk);
        chk("t6_err_w4", fetch_err, 1'b1);
        chk("t6_still_req", imem.req, 1'b1);
        chk("t6_still_addr", imem.addr, 32'h3000);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", imem.req, 1'b0);
        chk("t6_rst_err", fetch_err, 1'b0);
        chk("t6_rst_valid", if_valid, 1'b0);
        chk("t6_rst_pc", if_pc, RST_PC);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_idle_req", imem.req, 1'b0);
        @(negedge clk);
        chk("t6_late_ready_ignored", if_valid, 1'b0);
        chk("t6_refetch_addr", imem.addr, 32'h3000);

        // Randomized run against the program-order scoreboard.
        do_reset(1'b1);
        sb_on = 1'b1;
        wait_run = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            id_stall = ($urandom_range(0, 3) == 0);
            id_redirect = ($urandom_range(0, 15) == 0);
            if (id_redirect) begin
                mis = ($urandom_range(0, 7) == 0);
                redir_target = 32'h0000_4000 + 32'($urandom_range(0, 255)) * 32'd4;
                if (mis) redir_target = redir_target | 32'd2;
                id_redirect_op = 2'($urandom_range(1, 3));
                r.target = redir_target;
                r.mis = mis;
                sb_q.push_back(r);
            end else begin
                id_redirect_op = NPC_PLUS4;
            end
            // Memory latency stays under the timeout threshold.
            if (imem.req) begin
                mem_ready = (wait_run >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
                wait_run = mem_ready ? 0 : wait_run + 1;
            end else begin
                mem_ready = $urandom_range(0, 1) != 0;
                wait_run = 0;
            end
        end
        @(negedge clk);
        id_redirect = 1'b0;
        id_stall = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        sb_on = 1'b0;
        chk("sb_consumed_enough", 32'(n_consumed >= 200), 32'd1);
        chk("sb_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
